hybrid_pwm_sd_multi: RTL and testbench
======================================

# hybrid_pwm_sd_multi

N-channel hybrid PWM / sigma-delta audio DAC: P-bit free-running PWM whose per-period threshold is chosen by a first-order sigma-delta with F fractional bits. One shared scale/accumulate datapath serves all channels round-robin. Includes a parametrised anti-pop ramp, terminate/done handshake and optional periodic residue dump. Sits between the audio mixer output and the board's 1-bit audio pins.

## Interface
- CHANNELS, 2: channel count, ≥1.
- DWIDTH, 16: input sample width, unsigned offset-binary.
- PWMBITS, 5: PWM counter width P, ≥2.
- FRACBITS, 11: sigma-delta fractional width F, ≤ DWIDTH.
- DUMP_LOG2, 8: tick period is 2^DUMP_LOG2 PWM periods.
- DUMP_ENA, 1: 1 = tick also resets every channel residue.
- RAMP_START, 16'hF800: ramp value at reset and termination target.
- RAMP_STEP, 4: ramp increment per tick.
- clk  in  1  audio DAC clock.
- reset  in  1  asynchronous, active-high reset.
- d  in  CHANNELS*DWIDTH  samples, channel c at [c*DWIDTH +: DWIDTH].
- terminate  in  1  level request to ramp up to RAMP_START before core change.
- q  out  CHANNELS  1-bit DAC outputs.
- ready  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- Counter cnt: P bits, free-running, wraps MAX=2^P−1 → 0.
- Per channel c, at each edge: if cnt==MAX, q[c]<=1; else if cnt==thr[c], q[c]<=0. The MAX set has priority.
- thr range 0..2^P−2, so duty is never 100%. High time is thr+1 clocks per 2^P-clock period.
- Source select: src = d[ch] in RUN, else ramp register r.
- Pipeline for channel index ch:
  - Edge at cnt==MAX−2: m <= src.
  - Edge at cnt==MAX−1: inc <= (m*(2^P−2)) >> (DWIDTH−F). Width P+F, truncate.
  - Edge at cnt==MAX: sig[ch] <= inc + sig[ch][F−1:0]; thr[ch] <= new sig[ch] >> F; ch <= (ch+1) mod CHANNELS.
- Each channel updates once every CHANNELS PWM periods.
- Overflow impossible: inc+residue < (2^P−1)·2^F.
- Tick: counter tc (DUMP_LOG2 bits) increments at every cnt==MAX edge. tick is asserted for exactly the one clock after an update edge where tc wrapped to 0.
- On tick, if DUMP_ENA: all sig[c][F−1:0] <= 2^(F−1). Never coincides with an update edge.
- State machine (mid = 2^(DWIDTH−1)); r changes only on tick:
  - INIT: r <= max(r−RAMP_STEP, mid). Go to RUN on the tick where r is already mid. terminate is ignored.
  - RUN: r held at mid. terminate=1 at any edge goes to TERM.
  - TERM: r <= min(r+RAMP_STEP, RAMP_START). Go to DONE on the tick where r is already RAMP_START. terminate=0 at any edge goes to INIT.
  - DONE: r held. terminate=0 goes to INIT.
- Outputs: ready = (state==RUN); done = (state==DONE). Both registered from state.

## Timing
- Reset values:
  - cnt=MAX, ch=0, tc=0, tick=0, m=0, inc=0.
  - q all 0, thr all 2^P−2, sig[c] = ((2^P−2)<<F) | 2^(F−1).
  - state INIT, r=RAMP_START, ready=0, done=0.
- Reset deassertion mid-period restarts from cnt=MAX; no partial state is retained.
- First q rise: edge after first clock out of reset.
- Sample-to-output latency: sample captured at cnt==MAX−2; its thr governs the PWM period starting the following cycle. Outputs change only at period boundaries.
- d needs no handshake. It is sampled once per channel every CHANNELS periods; the host holds it or changes it freely.
- terminate in INIT is ignored; no latching. A later RUN sample is required.
- terminate toggling inside TERM/DONE is evaluated every clock. r continues from its current value; no jump.
- A state change and a tick in the same edge: the new state's ramp rule applies from the next tick.

## Test plan
Default params unless noted; P=5, F=11, CHANNELS=2.
- RAMP_STEP=16'h0800, DUMP_LOG2=1, terminate=0 -> r steps F800,F000…8000 every 2 periods; ready rises on the tick after r==8000 (15 ticks + 1); q shows no thr jump larger than 2 between updates.
- RUN, d0=16'h8000, d1=16'h0000 -> q[0] high exactly 16 of 32 clocks every period; q[1] high exactly 1 of 32.
- RUN, d0=16'hFFFF -> inc=61439; thr[0] only 29 or 30, never 31; q[0] never high for a full period.
- DUMP_ENA=1 vs 0, d0=16'h8001 held -> residue observed reset to 1024 one clock after each tc wrap with DUMP_ENA=1; no reset with 0.
- RUN, terminate=1 -> TERM, r ramps to F800, done=1; drop terminate -> INIT, done=0, r ramps down from F800, ready returns.
- Assert reset during TERM with r mid-ramp -> all reset values within one edge-free interval; terminate held high afterwards is ignored until RUN.

Source files
------------

// File: rtl/hybrid_pwm_sd_multi.sv
// N-channel hybrid PWM / first-order sigma-delta audio DAC. One shared scale/accumulate
// datapath serves the channels round-robin; an anti-pop ramp drives the outputs outside RUN.
module hybrid_pwm_sd_multi #(
  parameter int                CHANNELS   = 2,
  parameter int                DWIDTH     = 16,
  parameter int                PWMBITS    = 5,
  parameter int                FRACBITS   = 11,
  parameter int                DUMP_LOG2  = 8,
  parameter bit                DUMP_ENA   = 1'b1,
  parameter logic [DWIDTH-1:0] RAMP_START = 16'hF800,
  parameter logic [DWIDTH-1:0] RAMP_STEP  = 16'd4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS*DWIDTH-1:0] d,
  input  logic                       terminate,
  output logic [CHANNELS-1:0]        q,
  output logic                       ready,
  output logic                       done
);

  localparam int SW  = PWMBITS + FRACBITS;
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [PWMBITS-1:0]  CNT_MAX  = '1;
  localparam logic [PWMBITS-1:0]  THR_TOP  = CNT_MAX - PWMBITS'(1);
  localparam logic [PWMBITS-1:0]  CNT_LOAD = CNT_MAX - PWMBITS'(2);
  localparam logic [FRACBITS-1:0] RES_HALF = FRACBITS'(1) << (FRACBITS - 1);
  localparam logic [SW-1:0]       SIG_RST  = {THR_TOP, RES_HALF};
  localparam logic [DWIDTH-1:0]   MID      = DWIDTH'(1) << (DWIDTH - 1);
  localparam logic [CHW-1:0]      CH_LAST  = CHW'(CHANNELS - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_TERM, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [DWIDTH-1:0]   r_ramp, w_ramp_nxt;
  logic                r_ready, r_done;

  logic [PWMBITS-1:0]  r_cnt;
  logic [CHW-1:0]      r_ch;
  logic [DUMP_LOG2-1:0] r_tc;
  logic                r_tick;
  logic [DWIDTH-1:0]   r_m;
  logic [SW-1:0]       r_inc;

  logic [DWIDTH-1:0]         w_samp [CHANNELS];
  logic [DWIDTH-1:0]         w_src;
  logic [DWIDTH+PWMBITS-1:0] w_prod;
  logic [SW-1:0]             w_inc;
  logic [DWIDTH:0]           w_ramp_sum;
  logic [DWIDTH-1:0]         w_ramp_up, w_ramp_dn;

  assign w_src  = (r_state == S_RUN) ? w_samp[r_ch] : r_ramp;
  // Scaling by 2^P-2 keeps the largest threshold one below MAX, so duty never reaches 100%.
  assign w_prod = {{PWMBITS{1'b0}}, r_m} * {{DWIDTH{1'b0}}, THR_TOP};
  assign w_inc  = w_prod[DWIDTH-FRACBITS +: SW];

  assign w_ramp_sum = {1'b0, r_ramp} + {1'b0, RAMP_STEP};
  assign w_ramp_up  = (w_ramp_sum > {1'b0, RAMP_START}) ? RAMP_START : w_ramp_sum[DWIDTH-1:0];
  assign w_ramp_dn  = ({1'b0, r_ramp} < ({1'b0, MID} + {1'b0, RAMP_STEP})) ? MID
                                                                          : (r_ramp - RAMP_STEP);

  // Shared timing and scale pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= CNT_MAX;
      r_ch   <= '0;
      r_tc   <= '0;
      r_tick <= 1'b0;
      r_m    <= '0;
      r_inc  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
      if (r_cnt == CNT_LOAD) r_m   <= w_src;
      if (r_cnt == THR_TOP)  r_inc <= w_inc;
      if (r_cnt == CNT_MAX) begin
        r_ch   <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
        r_tc   <= r_tc + 1'b1;
        r_tick <= &r_tc;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SW-1:0]      r_sig;
    logic [PWMBITS-1:0] r_thr;
    logic               r_q;
    logic [SW-1:0]      w_sum;

    assign w_samp[c] = d[c*DWIDTH +: DWIDTH];
    assign w_sum     = r_inc + {{PWMBITS{1'b0}}, r_sig[FRACBITS-1:0]};
    assign q[c]      = r_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sig <= SIG_RST;
        r_thr <= THR_TOP;
        r_q   <= 1'b0;
      end else begin
        if (r_cnt == CNT_MAX)    r_q <= 1'b1;
        else if (r_cnt == r_thr) r_q <= 1'b0;
        if ((r_cnt == CNT_MAX) && (r_ch == CHW'(c))) begin
          r_sig <= w_sum;
          r_thr <= w_sum[SW-1 -: PWMBITS];
        end else if (DUMP_ENA && r_tick) begin
          r_sig[FRACBITS-1:0] <= RES_HALF;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_ramp  <= RAMP_START;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ramp  <= w_ramp_nxt;
      r_ready <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // The ramp rule of the state current at a tick applies; terminate is a level checked every clock.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    w_state_nxt = r_state;
    w_ramp_nxt  = r_ramp;
    unique case (r_state)
      S_INIT: begin
        if (r_tick) begin
          if (r_ramp == MID) w_state_nxt = S_RUN;
          else               w_ramp_nxt  = w_ramp_dn;
        end
      end
      S_RUN: begin
        if (terminate) w_state_nxt = S_TERM;
      end
      S_TERM: begin
        if (r_tick) begin
          if (r_ramp == RAMP_START) w_state_nxt = S_DONE;
          else                      w_ramp_nxt  = w_ramp_up;
        end
        if (!terminate) w_state_nxt = S_INIT;
      end
      S_DONE: begin
        if (!terminate) w_state_nxt = S_INIT;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign ready = r_ready;
  assign done  = r_done;

endmodule

// File: tb/tb_hybrid_pwm_sd_multi.sv
// Directed bench for hybrid_pwm_sd_multi: two instances (residue dump on / off) with a fast ramp
// (step 0x800, tick every 2 periods); q high-times per period are compared to hand-computed values.
module tb_hybrid_pwm_sd_multi;

  localparam int CH = 2;
  localparam int DW = 16;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             terminate = 1'b0;
  logic [CH*DW-1:0] d         = '0;
  logic [CH-1:0]    q_a, q_b;
  logic             ready_a, done_a, ready_b, done_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int run_a0, run_a1, run_b0;
  int hi_a0[$];
  int hi_a1[$];
  int hi_b0[$];

  always #5 clk = ~clk;

  hybrid_pwm_sd_multi #(
    .CHANNELS(CH), .DWIDTH(DW), .PWMBITS(5), .FRACBITS(11), .DUMP_LOG2(1),
    .DUMP_ENA(1'b1), .RAMP_START(16'hF800), .RAMP_STEP(16'h0800)
  ) u_dut_a (
    .clk(clk), .reset(reset), .d(d), .terminate(terminate),
    .q(q_a), .ready(ready_a), .done(done_a)
  );

  hybrid_pwm_sd_multi #(
    .CHANNELS(CH), .DWIDTH(DW), .PWMBITS(5), .FRACBITS(11), .DUMP_LOG2(1),
    .DUMP_ENA(1'b0), .RAMP_START(16'hF800), .RAMP_STEP(16'h0800)
  ) u_dut_b (
    .clk(clk), .reset(reset), .d(d), .terminate(terminate),
    .q(q_b), .ready(ready_b), .done(done_b)
  );

  // Posedges since reset release; update edges fall on 1+32n, tick actions on 64k-30.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // High-time of each completed PWM period, index k = period starting at update edge k.
  always @(negedge clk) begin
    if (reset) begin
      run_a0 = 0; run_a1 = 0; run_b0 = 0;
    end else begin
      if (q_a[0]) run_a0++; else if (run_a0 != 0) begin hi_a0.push_back(run_a0); run_a0 = 0; end
      if (q_a[1]) run_a1++; else if (run_a1 != 0) begin hi_a1.push_back(run_a1); run_a1 = 0; end
      if (q_b[0]) run_b0++; else if (run_b0 != 0) begin hi_b0.push_back(run_b0); run_b0 = 0; end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int qq[$], input int i);
    if (i < 0 || i >= qq.size()) return -1;
    return qq[i];
  endfunction

  function automatic int next_tick(input int e);
    return 64 * ((e + 30) / 64 + 1) - 30;
  endfunction

  task automatic last8(input int qq[$], output int s, output int mn, output int mx);
    s = 0; mn = 1000; mx = -1;
    if (qq.size() < 8) return;
    for (int i = qq.size() - 8; i < qq.size(); i++) begin
      s += qq[i];
      if (qq[i] < mn) mn = qq[i];
      if (qq[i] > mx) mx = qq[i];
    end
  endtask

  task automatic wait_periods(input int n);
    repeat (n * 32) @(negedge clk);
    #1;
  endtask

  // Release reset and follow the INIT ramp F800 -> 8000 (15 steps, RUN on the 16th tick).
  task automatic release_and_ramp(input bit with_jump);
    bit done_seen;
    int mj, dl;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_rise_a", q_a, 2'b11);
    check("first_rise_b", q_b, 2'b11);
    done_seen = 1'b0;
    while (!ready_a && cyc < 1100) begin
      @(negedge clk);
      done_seen |= done_a;
    end
    check("ready_rise_cyc", cyc, 994);
    check("ready_b", ready_b, 1);
    check("done_in_init", done_seen, 0);
    #1;
    check("ch1_p0_high", at(hi_a1, 0), 31);
    check("ch1_p1_high", at(hi_a1, 1), 30);
    check("ch0_p2_high", at(hi_a0, 2), 29);
    if (with_jump) begin
      mj = 0;
      for (int i = 1; i < hi_a1.size(); i++) begin
        dl = hi_a1[i] - hi_a1[i-1]; if (dl < 0) dl = -dl; if (dl > mj) mj = dl;
      end
      for (int i = 3; i < hi_a0.size(); i++) begin
        dl = hi_a0[i] - hi_a0[i-1]; if (dl < 0) dl = -dl; if (dl > mj) mj = dl;
      end
      check("ramp_periods_seen", (hi_a1.size() >= 30), 1);
      check("ramp_jump_le2", (mj <= 2), 1);
    end
  endtask

  initial begin
    int s, mn, mx, e, exp_cyc;

    #23;
    check("rst_q_a", q_a, 2'b00);
    check("rst_q_b", q_b, 2'b00);
    check("rst_ready", ready_a, 0);
    check("rst_done", done_a, 0);

    release_and_ramp(1'b1);

    // Mid-scale and zero: thr 15 and 0.
    d[15:0] = 16'h8000; d[31:16] = 16'h0000;
    wait_periods(14);
    check("run_8000_a0", at(hi_a0, hi_a0.size() - 1), 16);
    check("run_8000_b0", at(hi_b0, hi_b0.size() - 1), 16);
    check("run_0000_a1", at(hi_a1, hi_a1.size() - 1), 1);

    // Full scale: inc 61439, dumped residue 1024 gives thr 30; free-running gives 29/30.
    d[15:0] = 16'hFFFF;
    wait_periods(14);
    last8(hi_a0, s, mn, mx);
    check("ffff_dump_sum8", s, 248);
    last8(hi_b0, s, mn, mx);
    check("ffff_nodump_max", mx, 31);
    check("ffff_nodump_min_ge30", (mn >= 30), 1);

    // inc = 16*2048+1536: dump pins thr at 17; free-running carries 3 of every 4 updates.
    d[15:0] = 16'h8EEF;
    wait_periods(14);
    last8(hi_a0, s, mn, mx);
    check("frac_dump_sum8", s, 144);
    last8(hi_b0, s, mn, mx);
    check("frac_nodump_sum8", s, 142);

    // Terminate: ramp 8000 -> F800, DONE on the 16th TERM tick.
    @(negedge clk);
    terminate = 1'b1;
    e = cyc + 1;
    exp_cyc = next_tick(e) + 15 * 64;
    @(negedge clk);
    check("term_ready_fall", ready_a, 0);
    while (!done_a && cyc < exp_cyc + 100) @(negedge clk);
    check("done_rise_cyc", cyc, exp_cyc);
    check("done_b", done_b, 1);
    d[15:0] = 16'hFFFF;
    wait_periods(8);
    check("done_duty_a0", at(hi_a0, hi_a0.size() - 1), 30);
    check("done_duty_a1", at(hi_a1, hi_a1.size() - 1), 30);

    // Drop terminate: back to INIT, ramp down from F800, ready returns.
    @(negedge clk);
    terminate = 1'b0;
    e = cyc + 1;
    exp_cyc = next_tick(e) + 15 * 64;
    @(negedge clk);
    check("drop_done_fall", done_a, 0);
    check("drop_ready_low", ready_a, 0);
    while (!ready_a && cyc < exp_cyc + 100) @(negedge clk);
    check("ready_return_cyc", cyc, exp_cyc);

    // Reset asserted mid-ramp in TERM while q is high, terminate held high afterwards.
    @(negedge clk);
    terminate = 1'b1;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 64 && q_a != 2'b11; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midterm_rst_q_a", q_a, 2'b00);
    check("midterm_rst_q_b", q_b, 2'b00);
    check("midterm_rst_ready", ready_a, 0);
    check("midterm_rst_done", done_a, 0);
    repeat (3) @(negedge clk);
    hi_a0.delete(); hi_a1.delete(); hi_b0.delete();
    release_and_ramp(1'b0);
    @(negedge clk);
    check("run_then_term_ready", ready_a, 0);
    check("run_then_term_done", done_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
